// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack, decode valid/ready and
// the resolved-branch inputs.
//   master : fetch_pc_unit side (drives imem_req/addr and inst_*)
//   slave  : memory / decode / branch-unit side
interface fetch_pc_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  logic            br_valid;
  logic            br_taken;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] br_imm;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, br_valid, br_taken, br_pc, br_imm
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_ack, imem_rdata, inst_ready, br_valid, br_taken, br_pc, br_imm
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter and instruction-fetch stage.
// Fetches words over imem req/ack, hands them to decode over valid/ready and
// redirects to br_pc + br_imm on a taken branch, flushing any in-flight fetch.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (master) : imem_req/addr/ack/rdata, inst_valid/ready/data/pc,
//                  br_valid/taken/pc/imm
//   timeout_err  : sticky, set after TIMEOUT_CYCLES fetch cycles with no ack
//   misalign_err : sticky misaligned-redirect trap (FETCH_MISALIGN_TRAP_EN only)
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_pc_unit_if.master bus,
  output logic            timeout_err
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              valid_q, valid_d;
  logic              req_q;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   target_c;
  logic              redirect_c;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
`endif

  // Redirect target; ERR ignores every input until reset
  assign target_c   = bus.br_pc + bus.br_imm;
  assign redirect_c = bus.br_valid && bus.br_taken && (state_q != ERR);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    terr_d  = terr_q;
    cnt_d   = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (bus.imem_ack) begin
          data_d  = bus.imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
            terr_d  = 1'b1;
            state_d = ERR;
          end
        end
      end
      HOLD: begin
        if (bus.inst_ready) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      ERR: state_d = ERR;
    endcase

    // Redirect overrides ack, ready and the timeout decision of this cycle
    if (redirect_c) begin
      pc_d    = pc_q;
      data_d  = data_q;
      ipc_d   = ipc_q;
      valid_d = 1'b0;
      terr_d  = terr_q;
      cnt_d   = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (target_c[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = ERR;
      end else begin
        pc_d    = target_c;
        state_d = IDLE;
      end
`else
      pc_d    = target_c & ~XLEN'(3);
      state_d = IDLE;
`endif
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers; imem_req is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      data_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      data_q  <= data_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      req_q   <= (state_d == FETCH);
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
  assign misalign_err = mis_q;
`endif

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst_data  = data_q;
  assign bus.inst_pc    = ipc_q;
  assign timeout_err    = terr_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed steps plus a randomized phase, checked
// every cycle against a transaction-level model of the fetch stage.
module tb_fetch_pc_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int unsigned TMO    = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_err;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc_unit_if bus();

  fetch_pc_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .timeout_err(timeout_err)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Model: what the fetch stage owes the outside world
  logic [31:0] m_pc, m_data, m_ipc;
  bit          m_req, m_valid, m_dead, m_terr, m_mis;
  int          m_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_pc = RST_PC; m_data = '0; m_ipc = '0;
    m_req = 0; m_valid = 0; m_dead = 0; m_terr = 0; m_mis = 0; m_wait = 0;
  endtask

  // One clock of the model, from the inputs presented for that clock
  task automatic model_step(input bit ack, input logic [31:0] rdata, input bit ready,
                            input bit bv, input bit bt, input logic [31:0] bpc,
                            input logic [31:0] bimm);
    logic [31:0] tgt;
    tgt = bpc + bimm;
    if (bv && bt && !m_dead) begin
      m_valid = 0; m_req = 0; m_wait = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt % 4 != 0) begin m_dead = 1; m_mis = 1; end
      else m_pc = tgt;
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (m_dead) begin
      // frozen until reset
    end else if (m_req) begin
      if (ack) begin
        m_data = rdata; m_ipc = m_pc; m_pc = m_pc + 4;
        m_req = 0; m_valid = 1; m_wait = 0;
      end else begin
        m_wait++;
        if (m_wait == TMO) begin m_req = 0; m_dead = 1; m_terr = 1; end
      end
    end else if (m_valid) begin
      if (ready) begin m_valid = 0; m_req = 1; end
    end else begin
      m_req = 1;  // one idle cycle before each new fetch stream
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(m_valid));
    if (m_valid) begin
      chk("inst_data", bus.inst_data, m_data);
      chk("inst_pc", bus.inst_pc, m_ipc);
    end
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif
  endtask

  task automatic cyc(input bit ack, input logic [31:0] rdata, input bit ready,
                     input bit bv, input bit bt, input logic [31:0] bpc,
                     input logic [31:0] bimm);
    bus.imem_ack = ack; bus.imem_rdata = rdata; bus.inst_ready = ready;
    bus.br_valid = bv; bus.br_taken = bt; bus.br_pc = bpc; bus.br_imm = bimm;
    model_step(ack, rdata, ready, bv, bt, bpc, bimm);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic mem(input bit ack, input bit ready);
    cyc(ack, $urandom, ready, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic br(input logic [31:0] bpc, input logic [31:0] bimm,
                    input bit ready, input bit ack);
    cyc(ack, $urandom, ready, 1'b1, 1'b1, bpc, bimm);
  endtask

  task automatic do_reset();
    bus.imem_ack = 0; bus.imem_rdata = '0; bus.inst_ready = 0;
    bus.br_valid = 0; bus.br_taken = 0; bus.br_pc = '0; bus.br_imm = '0;
    rst_n = 1'b0;
    #1;
    model_init();
    check_outputs();
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit ack, bv, bt;
    logic [31:0] bpc, bimm;

    do_reset();

    // Zero-wait memory, ready high: 0x100, 0x104, 0x108
    mem(0, 1); chk("tp1_addr0", bus.imem_addr, 32'h100);
    mem(1, 1); chk("tp1_pc0", bus.inst_pc, 32'h100);
    mem(1, 1); chk("tp1_addr1", bus.imem_addr, 32'h104);
    mem(1, 1); chk("tp1_pc1", bus.inst_pc, 32'h104);
    mem(1, 1); chk("tp1_addr2", bus.imem_addr, 32'h108);
    mem(1, 1); chk("tp1_pc2", bus.inst_pc, 32'h108);

    // Decode stall for 5 cycles, then resume at +4
    repeat (5) mem(1, 0);
    chk("tp2_hold_pc", bus.inst_pc, 32'h108);
    chk("tp2_hold_req", 32'(bus.imem_req), 32'h0);
    mem(1, 1); chk("tp2_next", bus.imem_addr, 32'h10C);

    // Branch while holding a word
    mem(1, 0);
    br(32'h200, 32'hFFFF_FFF0, 1'b0, 1'b0);
    chk("tp3_flush", 32'(bus.inst_valid), 32'h0);
    mem(0, 0); chk("tp3_target", bus.imem_addr, 32'h1F0);

    // Branch coincident with ack
    br(32'h40, 32'h20, 1'b1, 1'b1);
    chk("tp4_discard", 32'(bus.inst_valid), 32'h0);
    mem(0, 1); chk("tp4_target", bus.imem_addr, 32'h60);

    // Target and increment wrap-around
    br(32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0);
    mem(0, 1); chk("wrap_target", bus.imem_addr, 32'h4);
    br(32'hFFFF_FFF0, 32'hC, 1'b1, 1'b0);
    mem(0, 1); chk("wrap_top", bus.imem_addr, 32'hFFFF_FFFC);
    mem(1, 1);
    mem(1, 1); chk("wrap_inc", bus.imem_addr, 32'h0);

    // Not-taken branch is inert; redirect beats a simultaneous ready
    cyc(1'b0, $urandom, 1'b1, 1'b1, 1'b0, 32'h1234, 32'h10);
    mem(1, 0);
    br(32'h300, 32'h4, 1'b1, 1'b0);
    mem(0, 1); chk("rdy_prio", bus.imem_addr, 32'h304);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      ack  = m_req ? (m_wait >= 8 || $urandom_range(0, 2) == 0) : bit'($urandom_range(0, 1));
      bv   = ($urandom_range(0, 9) == 0);
      bt   = bit'($urandom_range(0, 1));
      bpc  = $urandom;
      bimm = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      bpc  = bpc & 32'hFFFF_FFFC;
      bimm = bimm & 32'hFFFF_FFFC;
`endif
      cyc(ack, $urandom, bit'($urandom_range(0, 1)), bv, bt, bpc, bimm);
    end

    // Misaligned target 0x16
    br(32'h10, 32'h6, 1'b0, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign_err), 32'h1);
    mem(1, 1);
    chk("mis_noreq", 32'(bus.imem_req), 32'h0);
`else
    mem(0, 0); chk("mis_masked", bus.imem_addr, 32'h14);
`endif

    do_reset();

    // Memory never acks
    mem(0, 1);
    repeat (14) mem(0, 1);
    chk("tmo_pre_err", 32'(timeout_err), 32'h0);
    chk("tmo_pre_req", 32'(bus.imem_req), 32'h1);
    mem(0, 1);
    chk("tmo_err", 32'(timeout_err), 32'h1);
    chk("tmo_req", 32'(bus.imem_req), 32'h0);
    br(32'h500, 32'h0, 1'b1, 1'b1);
    mem(1, 1);
    chk("tmo_sticky", 32'(timeout_err), 32'h1);

    do_reset();

    // Reset in the middle of a hold drops the word
    mem(0, 1);
    mem(1, 0);
    chk("mid_valid", 32'(bus.inst_valid), 32'h1);
    do_reset();
    mem(0, 1); chk("mid_restart", bus.imem_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
